// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port RAM between the instruction-fetch and memory stages.
// MEM wins by default; a starvation counter hands the port to IF after STARVE_MAX MEM wins.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall_if,
  output logic        stall_pipe
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  lat_q;
  logic [3:0]  starve_q, starve_d;
  logic        ram_en_q, ram_we_q;
  logic [31:0] ram_addr_q, ram_wdata_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        if_done_q, mem_done_q;
  logic        grant_if, grant_mem;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    starve_d  = starve_q;
    if (state_q == IDLE) begin
      if (if_req && (!mem_req || starve_q == STARVE_TOP)) grant_if = 1'b1;
      else if (mem_req)                                   grant_mem = 1'b1;
    end
    // Only a MEM win over a waiting IF counts toward starvation.
    if (grant_if || (grant_mem && !if_req)) starve_d = '0;
    else if (grant_mem && starve_q != STARVE_TOP) starve_d = starve_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      ram_en_q   <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      starve_q   <= starve_d;
      case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q     <= BUSY_MEM;
            lat_q       <= LAT_INIT;
            ram_en_q    <= 1'b1;
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
          end else if (grant_if) begin
            state_q     <= BUSY_IF;
            lat_q       <= LAT_INIT;
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= if_addr;
            ram_wdata_q <= '0;
          end
        end
        BUSY_IF: begin
          if (lat_q == 3'd0) begin
            if_rdata_q <= ram_rdata;
            if_done_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        BUSY_MEM: begin
          if (lat_q == 3'd0) begin
            // ram_we_q still holds the direction of this access; writes leave mem_rdata alone.
            if (!ram_we_q) mem_rdata_q <= ram_rdata;
            mem_done_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_done    = if_done_q;
  assign mem_done   = mem_done_q;
  assign stall_if   = if_req & ~if_done_q;
  assign stall_pipe = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model that tracks grants, latency and expected data.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        if_done, mem_done, ram_en, ram_we, stall_if, stall_pipe;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Initial RAM contents; address 0x10 holds the instruction used in the fetch scenario.
  function automatic logic [31:0] seed(input logic [7:0] a);
    if (a == 8'h10) return 32'h8C22_0004;
    return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // RAM behaviour: writes land when ram_en is seen; read data is only valid in the
  // cycle it should be sampled, random otherwise, so mistimed captures are exposed.
  logic [31:0] ram_mem [256];
  bit          ram_wr  [256];
  logic [7:0]  rd_addr = '0;
  int          rd_cnt = 0;

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      ram_mem[ram_addr[7:0]] <= ram_wdata;
      ram_wr[ram_addr[7:0]]  <= 1'b1;
    end
    if (ram_en && !ram_we) begin
      if (MEM_LAT == 1) ram_rdata <= ram_wr[ram_addr[7:0]] ? ram_mem[ram_addr[7:0]] : seed(ram_addr[7:0]);
      else begin
        rd_addr   <= ram_addr[7:0];
        rd_cnt    <= MEM_LAT - 1;
        ram_rdata <= $urandom;
      end
    end else if (rd_cnt == 1) begin
      ram_rdata <= ram_wr[rd_addr] ? ram_mem[rd_addr] : seed(rd_addr);
      rd_cnt    <= 0;
    end else begin
      if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      ram_rdata <= $urandom;
    end
  end

  // Reference model: one transaction at a time, done exactly MEM_LAT+1 edges after grant.
  logic [31:0] ref_mem [256];
  bit          ref_wr  [256];
  bit          m_busy = 0, m_is_if = 0, m_is_wr = 0;
  int          m_left = 0, m_starve = 0;
  logic [31:0] m_exp = '0, m_if_rdata = '0, m_mem_rdata = '0;
  logic        e_en, e_we, e_if_done, e_mem_done;
  logic [31:0] e_addr, e_wdata;
  logic [31:0] grant_addrs [$];

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : seed(a);
  endfunction

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic step();
    bit g_if, g_mem;
    g_if  = !m_busy && if_req && (!mem_req || m_starve == STARVE_MAX);
    g_mem = !m_busy && mem_req && !g_if;
    @(posedge clk);
    e_en = 0; e_if_done = 0; e_mem_done = 0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        if (m_is_if) begin
          e_if_done  = 1;
          m_if_rdata = m_exp;
        end else begin
          e_mem_done = 1;
          if (!m_is_wr) m_mem_rdata = m_exp;
        end
      end
    end else if (g_if || g_mem) begin
      m_busy = 1; m_is_if = g_if; m_left = MEM_LAT + 1; e_en = 1;
      if (g_if) begin
        e_we = 0; e_addr = if_addr; m_is_wr = 0;
        m_exp = ref_read(if_addr[7:0]);
        m_starve = 0;
      end else begin
        e_we = mem_we; e_addr = mem_addr; e_wdata = mem_wdata; m_is_wr = mem_we;
        if (mem_we) begin
          ref_mem[mem_addr[7:0]] = mem_wdata;
          ref_wr[mem_addr[7:0]]  = 1;
        end else m_exp = ref_read(mem_addr[7:0]);
        m_starve = if_req ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
      end
    end
    #1;
    check("ram_en", 32'(ram_en), 32'(e_en));
    if (e_en) begin
      grant_addrs.push_back(ram_addr);
      check("ram_addr", ram_addr, e_addr);
      check("ram_we", 32'(ram_we), 32'(e_we));
      if (e_we) check("ram_wdata", ram_wdata, e_wdata);
    end
    check("if_done", 32'(if_done), 32'(e_if_done));
    check("mem_done", 32'(mem_done), 32'(e_mem_done));
    check("if_rdata", if_rdata, m_if_rdata);
    check("mem_rdata", mem_rdata, m_mem_rdata);
    check("stall_if", 32'(stall_if), 32'(if_req & ~e_if_done));
    check("stall_pipe", 32'(stall_pipe), 32'(mem_req & ~e_mem_done));
    @(negedge clk);
  endtask

  task automatic cyc(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                     input logic [31:0] ma, input logic [31:0] mwd, input int n);
    if_req = ir; if_addr = ia; mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = mwd;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, ram_addr, 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    check({tag, "_if_done"}, 32'(if_done), 32'd0);
    check({tag, "_mem_done"}, 32'(mem_done), 32'd0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_left = 0; m_starve = 0; m_if_rdata = '0; m_mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_gr;
    // Power-on reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    check("por_stall_if", 32'(stall_if), 32'd0);
    rst = 1'b1;

    // IF-only fetch, granted on the first edge out of reset.
    cyc(1, 32'h10, 0, 0, 0, 0, MEM_LAT + 2);
    check("fetch_rdata", if_rdata, 32'h8C22_0004);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // MEM read so mem_rdata is non-zero, then a write that must leave it alone.
    cyc(0, 0, 1, 0, 32'h80, 0, MEM_LAT + 2);
    cyc(0, 0, 1, 1, 32'h20, 32'h0000_000C, MEM_LAT + 2);
    check("write_keeps_rdata", mem_rdata, seed(8'h80));
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Simultaneous requests: MEM first, IF on the idle cycle after mem_done.
    grant_addrs.delete();
    cyc(1, 32'h40, 1, 0, 32'h20, 0, MEM_LAT + 2);
    cyc(1, 32'h40, 0, 0, 0, 0, MEM_LAT + 2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    n_gr = grant_addrs.size();
    check("simul_grants", n_gr, 2);
    if (n_gr >= 2) begin
      check("simul_first_mem", grant_addrs[0], 32'h20);
      check("simul_then_if", grant_addrs[1], 32'h40);
    end

    // Starvation: continuous MEM pressure with IF waiting.
    grant_addrs.delete();
    cyc(1, 32'h40, 1, 0, 32'h80, 0, (STARVE_MAX + 2) * (MEM_LAT + 2));
    cyc(0, 0, 0, 0, 0, 0, MEM_LAT + 2);
    n_gr = grant_addrs.size();
    check("starve_grants", n_gr, STARVE_MAX + 2);
    if (n_gr >= STARVE_MAX + 2) begin
      check("starve_pre_mem", grant_addrs[STARVE_MAX - 1], 32'h80);
      check("starve_if_wins", grant_addrs[STARVE_MAX], 32'h40);
      check("starve_mem_again", grant_addrs[STARVE_MAX + 1], 32'h80);
    end

    // Request dropped right after grant still completes.
    cyc(1, 32'h10, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, MEM_LAT + 2);

    // Reset in the cycle after a grant abandons the access.
    cyc(1, 32'h44, 0, 0, 0, 0, 1);
    if_req = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, MEM_LAT + 3);
    cyc(1, 32'h10, 0, 0, 0, 0, MEM_LAT + 2);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Random traffic; requests often held so starvation and back-to-back grants occur.
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 99) < 65, {22'd0, 8'($urandom_range(0, 63)), 2'b00},
          $urandom_range(0, 99) < 60, $urandom_range(0, 2) == 0,
          {22'd0, 8'($urandom_range(0, 63)), 2'b00}, $urandom, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
